// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared logic unit.
// Requesters drive the master side; the arbiter is the slave.
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    reqValid;
  logic [3*NUM_REQ-1:0]  reqOpcode;
  logic [32*NUM_REQ-1:0] reqOperantA;
  logic [32*NUM_REQ-1:0] reqOperantB;
  logic [NUM_REQ-1:0]    reqAck;
  logic [NUM_REQ-1:0]    rspValid;
  logic [31:0]           rspResult;
  logic                  busy;

  modport master (
    output reqValid, reqOpcode, reqOperantA, reqOperantB,
    input  reqAck, rspValid, rspResult, busy
  );

  modport slave (
    input  reqValid, reqOpcode, reqOperantA, reqOperantB,
    output reqAck, rspValid, rspResult, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 32-bit logic unit: one grant per cycle, operand register
// then result register, response returned to the winner two cycles after its ack.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  logic_unit_arbiter_if.slave   bus
);
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DATA_W = 32;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     win_idx;
  logic               grant;
  logic [NUM_REQ-1:0] ack;
  logic [2:0]         sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  logic               vld_p1;
  logic [2:0]         op_p1;
  logic [DATA_W-1:0]  a_p1;
  logic [DATA_W-1:0]  b_p1;
  logic [NUM_REQ-1:0] id_p1;

  logic               vld_p2;
  logic [NUM_REQ-1:0] rsp_vld_p2;
  logic [DATA_W-1:0]  res_p2;

  function automatic logic [DATA_W-1:0] logic_op(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [15:0] a_h;
    logic signed [7:0]  a_b;
    a_h = signed'(a[15:0]);
    a_b = signed'(a[7:0]);
    case (op)
      3'b001:  logic_op = a & b;
      3'b010:  logic_op = a | b;
      3'b011:  logic_op = a ^ b;
      3'b100:  logic_op = DATA_W'(a_h);
      3'b101:  logic_op = DATA_W'(a_b);
      3'b110:  logic_op = {16'd0, a[15:0]};
      3'b111:  logic_op = {24'd0, a[7:0]};
      default: logic_op = '0;
    endcase
  endfunction

  // Arbitration: first pending requester at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j       = 0;
    grant   = 1'b0;
    win_idx = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    ack     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant && bus.reqValid[j]) begin
        grant   = 1'b1;
        win_idx = IDW'(j);
        sel_op  = bus.reqOpcode[3*j +: 3];
        sel_a   = bus.reqOperantA[32*j +: 32];
        sel_b   = bus.reqOperantB[32*j +: 32];
      end
    end
    if (reset) grant = 1'b0;
    if (grant) ack[win_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      rsp_vld_p2 <= '0;
      res_p2     <= '0;
    end else begin
      if (grant) rr_ptr <= (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      vld_p1     <= grant;
      // Stage 1 -> stage 2: compute and register result for the stage-1 owner
      vld_p2     <= vld_p1;
      rsp_vld_p2 <= vld_p1 ? id_p1 : '0;
      if (vld_p1) res_p2 <= logic_op(op_p1, a_p1, b_p1);
    end
  end

  // Arbitration -> stage 1: operand capture, data only
  always_ff @(posedge clock) begin
    if (grant) begin
      op_p1 <= sel_op;
      a_p1  <= sel_a;
      b_p1  <= sel_b;
      id_p1 <= ack;
    end
  end

  assign bus.reqAck    = ack;
  assign bus.rspValid  = rsp_vld_p2;
  assign bus.rspResult = res_p2;
  assign bus.busy      = vld_p1 | vld_p2;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: opcode table plus arbitration,
// latency, reset and idle sequences.
module tb_logic_unit_arbiter;
  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  logic_unit_arbiter_if #(.NUM_REQ(4)) bus ();

  logic_unit_arbiter #(.NUM_REQ(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          req;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.reqOpcode[3*i +: 3]    = op;
    bus.reqOperantA[32*i +: 32] = a;
    bus.reqOperantB[32*i +: 32] = b;
  endtask

  // Called at a negedge with reqValid idle; ends at a negedge, reqValid idle
  task automatic do_op(input int req, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    set_req(req, op, a, b);
    bus.reqValid = 4'(1 << req);
    #1 chk("op_ack", 32'(bus.reqAck), 32'(1 << req));
    @(negedge clock);
    bus.reqValid = 4'b0;
    #1 chk("op_rsp_t1", 32'(bus.rspValid), 32'h0);
    chk("op_busy_t1", 32'(bus.busy), 32'h1);
    @(negedge clock);
    #1 chk("op_rsp_t2", 32'(bus.rspValid), 32'(1 << req));
    chk("op_result", bus.rspResult, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0]  = '{1, 3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
    vecs[1]  = '{2, 3'b010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
    vecs[2]  = '{3, 3'b011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[3]  = '{0, 3'b100, 32'h0000_8081, 32'hDEAD_BEEF, 32'hFFFF_8081};
    vecs[4]  = '{1, 3'b101, 32'h0000_8081, 32'hDEAD_BEEF, 32'hFFFF_FF81};
    vecs[5]  = '{2, 3'b110, 32'h0000_8081, 32'hDEAD_BEEF, 32'h0000_8081};
    vecs[6]  = '{3, 3'b111, 32'h0000_8081, 32'hDEAD_BEEF, 32'h0000_0081};
    vecs[7]  = '{0, 3'b000, 32'h0000_8081, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{1, 3'b100, 32'h1234_7FFF, 32'h0, 32'h0000_7FFF};
    vecs[9]  = '{2, 3'b101, 32'hABCD_EF7F, 32'h0, 32'h0000_007F};
    vecs[10] = '{3, 3'b111, 32'hABCD_EFFE, 32'h0, 32'h0000_00FE};

    reset           = 1'b1;
    bus.reqValid    = '0;
    bus.reqOpcode   = '0;
    bus.reqOperantA = '0;
    bus.reqOperantB = '0;
    repeat (2) @(negedge clock);
    #1 chk("rst_ack", 32'(bus.reqAck), 32'h0);
    chk("rst_rspvalid", 32'(bus.rspValid), 32'h0);
    chk("rst_result", bus.rspResult, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    bus.reqValid = 4'hF;
    #1 chk("rst_ack_forced", 32'(bus.reqAck), 32'h0);
    @(negedge clock);
    reset        = 1'b0;
    bus.reqValid = 4'h0;

    // Opcode table, one isolated op per entry
    foreach (vecs[i]) do_op(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    repeat (2) @(negedge clock);

    // All four held from reset: round robin, responses 2 cycles later, no gaps
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'b011, 32'h0000_0010 + 32'(i), 32'hA5A5_0000);
    bus.reqValid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1 chk("rr_ack", 32'(bus.reqAck), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_rspvalid", 32'(bus.rspValid), 32'(1 << ((k - 2) % 4)));
        chk("rr_result", bus.rspResult, 32'hA5A5_0010 + 32'((k - 2) % 4));
      end else begin
        chk("rr_rspvalid_early", 32'(bus.rspValid), 32'h0);
      end
      if (k >= 1) chk("rr_busy", 32'(bus.busy), 32'h1);
      @(negedge clock);
    end
    bus.reqValid = 4'h0;
    repeat (3) @(negedge clock);

    // Fairness: req0 held, req2 raised once
    pulse_reset();
    set_req(0, 3'b001, 32'hFFFF_FFFF, 32'h1234_5678);
    set_req(2, 3'b010, 32'h0000_0000, 32'hCAFE_0000);
    bus.reqValid = 4'b0001;
    #1 chk("fair_ack0", 32'(bus.reqAck), 32'h1);
    @(negedge clock);
    bus.reqValid = 4'b0101;
    #1 chk("fair_ack1", 32'(bus.reqAck), 32'h4);
    @(negedge clock);
    bus.reqValid = 4'b0001;
    #1 chk("fair_ack2", 32'(bus.reqAck), 32'h1);
    chk("fair_rsp2", 32'(bus.rspValid), 32'h1);
    chk("fair_res2", bus.rspResult, 32'h1234_5678);
    @(negedge clock);
    #1 chk("fair_ack3", 32'(bus.reqAck), 32'h1);
    chk("fair_rsp3", 32'(bus.rspValid), 32'h4);
    chk("fair_res3", bus.rspResult, 32'hCAFE_0000);
    @(negedge clock);
    bus.reqValid = 4'b0000;
    #1 chk("fair_rsp4", 32'(bus.rspValid), 32'h1);
    repeat (3) @(negedge clock);

    // Reset in the cycle after an ack discards the op and rewinds rrPtr
    set_req(1, 3'b011, 32'hFFFF_FFFF, 32'h0);
    bus.reqValid = 4'b0010;
    #1 chk("mid_ack", 32'(bus.reqAck), 32'h2);
    @(negedge clock);
    bus.reqValid = 4'b0000;
    reset        = 1'b1;
    @(negedge clock);
    #1 chk("mid_rsp", 32'(bus.rspValid), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    bus.reqValid = 4'hF;
    #1 chk("mid_ack_rst", 32'(bus.reqAck), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("mid_rrptr", 32'(bus.reqAck), 32'h1);
    chk("mid_rsp2", 32'(bus.rspValid), 32'h0);
    chk("mid_busy2", 32'(bus.busy), 32'h0);
    @(negedge clock);
    bus.reqValid = 4'h0;
    #1 chk("mid_rsp3", 32'(bus.rspValid), 32'h0);
    @(negedge clock);
    #1 chk("post_rsp", 32'(bus.rspValid), 32'h1);
    chk("post_res", bus.rspResult, 32'h1234_5678);

    // Idle: nothing moves, result holds
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1 chk("idle_ack", 32'(bus.reqAck), 32'h0);
      chk("idle_rsp", 32'(bus.rspValid), 32'h0);
      chk("idle_busy", 32'(bus.busy), 32'h0);
      chk("idle_hold", bus.rspResult, 32'h1234_5678);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
